// File: rtl/spi_rd_engine.sv
// spi_rd_engine: SPI mode-0 read master. Shifts an address out MSB first, then
// reads burst_len+1 words back-to-back under a single chip-select window.
//
// Ports
//   spi_clk, spi_rst_n : system clock, asynchronous active-low reset
//   start              : transaction request, only honoured while idle
//   addr, burst_len    : captured when start is accepted
//   busy               : high for the whole transaction
//   spi_cs, spi_sclk   : slave select (active low), serial clock (CPOL=0)
//   spi_mosi_out       : serial address out, 0 during the data phase
//   spi_miso_in        : serial data in
//   spi_miso_out       : last completed word, held between strobes
//   data_valid         : one-cycle strobe per completed word
//
// Build option
//   SPI_RD_LSB_FIRST_EN : when defined, the first received bit of a word lands
//                         in bit 0; otherwise it lands in bit DATA_W-1.
module spi_rd_engine #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned BURST_W = 4
) (
  input  logic              spi_clk,
  input  logic              spi_rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BURST_W-1:0] burst_len,
  output logic              busy,
  output logic              spi_cs,
  output logic              spi_sclk,
  output logic              spi_mosi_out,
  input  logic              spi_miso_in,
  output logic [DATA_W-1:0] spi_miso_out,
  output logic              data_valid
);

  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned CNT_W   = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CS_SETUP = 3'd1;
  localparam logic [2:0] ST_ADDR     = 3'd2;
  localparam logic [2:0] ST_DATA     = 3'd3;
  localparam logic [2:0] ST_CS_HOLD  = 3'd4;

  logic [2:0]         state, state_nxt;
  logic [DIV_W-1:0]   div_cnt, div_cnt_nxt;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic [BURST_W-1:0] word_cnt, word_cnt_nxt;
  logic [BURST_W-1:0] burst_q, burst_q_nxt;
  logic [ADDR_W-1:0]  addr_sh, addr_sh_nxt;
  logic [DATA_W-1:0]  data_sh, data_sh_nxt;
  logic [DATA_W-1:0]  shift_in;
  logic [DATA_W-1:0]  miso_out_nxt;
  logic               busy_nxt, cs_nxt, sclk_nxt, mosi_nxt, valid_nxt;
  logic               half_tick;

  // State and registered outputs
  always_ff @(posedge spi_clk or negedge spi_rst_n) begin
    if (!spi_rst_n) begin
      state        <= ST_IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      word_cnt     <= '0;
      burst_q      <= '0;
      addr_sh      <= '0;
      data_sh      <= '0;
      busy         <= 1'b0;
      spi_cs       <= 1'b1;
      spi_sclk     <= 1'b0;
      spi_mosi_out <= 1'b0;
      spi_miso_out <= '0;
      data_valid   <= 1'b0;
    end else begin
      state        <= state_nxt;
      div_cnt      <= div_cnt_nxt;
      bit_cnt      <= bit_cnt_nxt;
      word_cnt     <= word_cnt_nxt;
      burst_q      <= burst_q_nxt;
      addr_sh      <= addr_sh_nxt;
      data_sh      <= data_sh_nxt;
      busy         <= busy_nxt;
      spi_cs       <= cs_nxt;
      spi_sclk     <= sclk_nxt;
      spi_mosi_out <= mosi_nxt;
      spi_miso_out <= miso_out_nxt;
      data_valid   <= valid_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt    = state;
    div_cnt_nxt  = '0;
    bit_cnt_nxt  = bit_cnt;
    word_cnt_nxt = word_cnt;
    burst_q_nxt  = burst_q;
    addr_sh_nxt  = addr_sh;
    data_sh_nxt  = data_sh;
    sclk_nxt     = spi_sclk;
    mosi_nxt     = spi_mosi_out;
    miso_out_nxt = spi_miso_out;
    valid_nxt    = 1'b0;

    // One half SCLK period has elapsed when the divider reaches its last count
    half_tick = (div_cnt == DIV_W'(CLK_DIV - 1));
    if (state != ST_IDLE && !half_tick) begin
      div_cnt_nxt = div_cnt + DIV_W'(1);
    end

`ifdef SPI_RD_LSB_FIRST_EN
    shift_in = (data_sh >> 1) | (DATA_W'(spi_miso_in) << (DATA_W - 1));
`else
    shift_in = (data_sh << 1) | DATA_W'(spi_miso_in);
`endif

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt    = ST_CS_SETUP;
          addr_sh_nxt  = addr;
          burst_q_nxt  = burst_len;
          bit_cnt_nxt  = '0;
          word_cnt_nxt = '0;
          // First address bit is presented during CS setup for full setup time
          mosi_nxt     = addr[ADDR_W-1];
        end
      end
      ST_CS_SETUP: begin
        if (half_tick) begin
          state_nxt   = ST_ADDR;
          bit_cnt_nxt = '0;
        end
      end
      ST_ADDR: begin
        if (half_tick) begin
          if (!spi_sclk) begin
            sclk_nxt = 1'b1;
          end else begin
            // MOSI only moves on the falling edge so it is stable at the rise
            sclk_nxt = 1'b0;
            if (bit_cnt == CNT_W'(ADDR_W - 1)) begin
              state_nxt   = ST_DATA;
              bit_cnt_nxt = '0;
              mosi_nxt    = 1'b0;
            end else begin
              bit_cnt_nxt = bit_cnt + CNT_W'(1);
              addr_sh_nxt = addr_sh << 1;
              mosi_nxt    = addr_sh_nxt[ADDR_W-1];
            end
          end
        end
      end
      ST_DATA: begin
        if (half_tick) begin
          if (!spi_sclk) begin
            // Sample MISO in the cycle SCLK rises
            sclk_nxt    = 1'b1;
            data_sh_nxt = shift_in;
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              miso_out_nxt = shift_in;
              valid_nxt    = 1'b1;
            end
          end else begin
            sclk_nxt = 1'b0;
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              bit_cnt_nxt = '0;
              if (word_cnt == burst_q) begin
                state_nxt = ST_CS_HOLD;
              end else begin
                word_cnt_nxt = word_cnt + BURST_W'(1);
              end
            end else begin
              bit_cnt_nxt = bit_cnt + CNT_W'(1);
            end
          end
        end
      end
      ST_CS_HOLD: begin
        if (half_tick) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
    cs_nxt   = (state_nxt == ST_IDLE);
  end

endmodule
